// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory, then releases the core after a flush delay.
// Define IMEM_LOADER_CHECKSUM_EN to treat the s_last beat as a running-sum checksum instead of a program word.
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        load_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        done,
  output logic        err,
  output logic [6:0]  word_count
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {LOAD, FLUSH, RUN, ERROR} state_t;
  state_t state;
  logic [FW-1:0] flush_cnt;
  logic accept;
  logic full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif
  assign accept = s_valid && s_ready;
  assign full = word_count == 7'(DEPTH_WORDS);
  assign s_ready = state == LOAD;
  assign core_reset = state != RUN;
  assign pc_enable = state == RUN;
  assign if_id_enable = state == RUN;
  assign done = state == RUN;
  assign err = state == ERROR;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      flush_cnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        LOAD: begin
          flush_cnt <= '0;
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (s_last) state <= (s_data == sum) ? FLUSH : ERROR;
            else if (full) state <= ERROR;
            else begin
              mem_we <= 1'b1;
              mem_addr <= {word_count[5:0], 2'b00};
              mem_wdata <= s_data;
              word_count <= word_count + 7'd1;
              sum <= sum + s_data;
            end
`else
            if (full) state <= ERROR;
            else begin
              mem_we <= 1'b1;
              mem_addr <= {word_count[5:0], 2'b00};
              mem_wdata <= s_data;
              word_count <= word_count + 7'd1;
              if (s_last) state <= FLUSH;
            end
`endif
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FW'(FLUSH_CYCLES - 1)) state <= RUN;
        end
        default: if (load_req) begin
          state <= LOAD;
          word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum <= '0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a queue-based model of expected writes and outcome.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int FLUSH = 3;
  logic clk = 1'b0;
  logic reset, s_valid, s_last, load_req;
  logic [31:0] s_data;
  logic s_ready, mem_we, core_reset, pc_enable, if_id_enable, done, err;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0] word_count;
  int checks = 0;
  int errors = 0;
  logic [7:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] prog[$];
  always #5 clk = ~clk;
  imem_loader #(.DEPTH_WORDS(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .load_req(load_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset(core_reset), .pc_enable(pc_enable),
    .if_id_enable(if_id_enable), .done(done), .err(err), .word_count(word_count)
  );
  always @(negedge clk) if (mem_we) begin
    wa.push_back(mem_addr);
    wd.push_back(mem_wdata);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // idle cycles carry junk data and stray load_req pulses, then one valid beat
  task automatic beat(input logic [31:0] d, input logic last, input int gap);
    repeat (gap) begin
      s_valid = 1'b0;
      s_data = $urandom;
      s_last = 1'($urandom);
      load_req = 1'($urandom);
      @(negedge clk);
    end
    load_req = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    @(negedge clk);
    s_valid = 1'b0;
    s_data = $urandom;
    s_last = 1'($urandom);
  endtask
  task automatic restart();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("restart_core_reset", 32'(core_reset), 32'd1);
    check("restart_word_count", 32'(word_count), 32'd0);
    check("restart_err", 32'(err), 32'd0);
    check("restart_s_ready", 32'(s_ready), 32'd1);
  endtask
  task automatic run_load(input int gap, input bit bad);
    logic [31:0] sum = 0;
    int n = prog.size();
    int cnt = 0;
    bit exp_err = 1'b0;
    wa.delete();
    wd.delete();
    foreach (prog[i]) begin
      sum += prog[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
      beat(prog[i], 1'b0, gap < 0 ? int'($urandom_range(0, 2)) : gap);
`else
      beat(prog[i], i == n - 1, gap < 0 ? int'($urandom_range(0, 2)) : gap);
`endif
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    beat(bad ? sum + 32'd1 : sum, 1'b1, 0);
    exp_err = bad;
`endif
    if (exp_err) begin
      check("sum_err", 32'(err), 32'd1);
      check("sum_err_done", 32'(done), 32'd0);
      check("sum_err_core_reset", 32'(core_reset), 32'd1);
      @(negedge clk);
    end else begin
      while (core_reset && cnt < 20) begin
        load_req = cnt == 0;
        @(negedge clk);
        load_req = 1'b0;
        cnt++;
      end
      check("flush_len", 32'(cnt), 32'(FLUSH));
      check("run_done", 32'(done), 32'd1);
      check("run_pc_enable", 32'(pc_enable), 32'd1);
      check("run_if_id_enable", 32'(if_id_enable), 32'd1);
      check("run_s_ready", 32'(s_ready), 32'd0);
      check("run_err", 32'(err), 32'd0);
    end
    check("load_word_count", 32'(word_count), 32'(n));
    check("load_writes", 32'(wa.size()), 32'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check("write_addr", 32'(wa[i]), 32'(4 * i));
      check("write_data", wd[i], prog[i]);
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_pc_enable", 32'(pc_enable), 32'd0);
    check("rst_if_id_enable", 32'(if_id_enable), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    prog = '{32'hE2110000, 32'hE0805183, 32'hE7D12000};
    run_load(0, 1'b0);
    restart();
    prog = '{32'h12345678, 32'h9ABCDEF0};
    run_load(1, 1'b0);
    repeat (6) begin
      restart();
      prog.delete();
      repeat ($urandom_range(1, DEPTH)) prog.push_back($urandom);
      run_load(-1, 1'($urandom));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    restart();
    prog = '{32'h1, 32'h2};
    run_load(0, 1'b0);
    restart();
    run_load(0, 1'b1);
`endif
    restart();
    wa.delete();
    repeat (DEPTH + 1) beat($urandom, 1'b0, 0);
    @(negedge clk);
    check("ovf_writes", 32'(wa.size()), 32'(DEPTH));
    if (wa.size() > 0) check("ovf_last_addr", 32'(wa[wa.size() - 1]), 32'h0FC);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_core_reset", 32'(core_reset), 32'd1);
    check("ovf_word_count", 32'(word_count), 32'(DEPTH));
    check("ovf_s_ready", 32'(s_ready), 32'd0);
    restart();
    wa.delete();
    beat(32'hAAAA0001, 1'b0, 0);
    reset = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hAAAA0002;
    @(negedge clk);
    reset = 1'b0;
    s_valid = 1'b0;
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("midrst_word_count", 32'(word_count), 32'd0);
    check("midrst_writes", 32'(wa.size()), 32'd1);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    prog = '{32'hBBBB0001, 32'hBBBB0002};
    run_load(0, 1'b0);
    wa.delete();
    load_req = 1'b1;
    s_valid = 1'b1;
    s_last = 1'b1;
    s_data = 32'hDEADBEEF;
    @(negedge clk);
    load_req = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("req_beat_word_count", 32'(word_count), 32'd0);
    check("req_beat_writes", 32'(wa.size()), 32'd0);
    check("req_beat_s_ready", 32'(s_ready), 32'd1);
    check("req_beat_err", 32'(err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
